// File: rtl/streaming_fifo_param_pkg.sv
// Shared helpers for the parametrised streaming FIFO: width math and pointer wrap.
package streaming_fifo_pkg;

    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // Width able to hold 0..depth inclusive, since count reaches depth.
    function automatic int cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    // Explicit compare keeps non-power-of-two depths correct.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/streaming_fifo_param_if.sv
// AXI-Stream style handshake bundle (data, valid, ready) for the FIFO ports.
interface streaming_fifo_param_if #(
    parameter int WIDTH = 72
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/streaming_fifo_param_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with enable.
module fifo_sdp_ram
    import streaming_fifo_pkg::*;
#(
    parameter int WIDTH = 72,
    parameter int DEPTH = 6272,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/streaming_fifo_param.sv
// Parametrised stream FIFO: RAM storage plus registered output stage, with
// occupancy monitoring, almost flags, high-water mark and synchronous flush.
module streaming_fifo_param
    import streaming_fifo_pkg::*;
#(
    parameter int   WIDTH     = 72,
    parameter int   DEPTH     = 6272,
    parameter int   AF_THRESH = DEPTH - 16,
    parameter int   AE_THRESH = 16,
    localparam int  CNT_W     = cnt_width(DEPTH)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    flush,
    input  logic                    maxcount_clr,
    output logic [CNT_W-1:0]        count,
    output logic [CNT_W-1:0]        maxcount,
    output logic                    almost_full,
    output logic                    almost_empty,
    streaming_fifo_param_if.slave   in0_V,
    streaming_fifo_param_if.master  out_V
);

    localparam int PTR_W = clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] ram_occ, count_q, max_q;
    logic [CNT_W-1:0] count_next, ram_occ_next, count_sel;
    logic             valid_q, af_q, ae_q;
    logic             in_ready, out_valid, push, pop, refill, ram_re;

    assign in_ready = !ap_rst && !flush && (count_q != CNT_W'(DEPTH));
    assign out_valid = valid_q && !flush;
    assign push = in0_V.tvalid && in_ready;
    assign pop = out_valid && out_V.tready;
    assign refill = (ram_occ != '0) && (!valid_q || pop);
    assign ram_re = refill && !flush && !ap_rst;

    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);
    assign ram_occ_next = ram_occ + CNT_W'(push) - CNT_W'(refill);
    assign count_sel = (ap_rst || flush) ? '0 : count_next;

    fifo_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in0_V.tdata),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (out_V.tdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_occ <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            max_q   <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_occ <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            if (maxcount_clr) begin
                max_q <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (ram_re) begin
                rd_ptr  <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
            ram_occ <= ram_occ_next;
            count_q <= count_next;
            if (maxcount_clr || (count_next > max_q)) begin
                max_q <= count_next;
            end
        end
    end

    // Flags follow count_sel, which already folds in reset and flush.
    always_ff @(posedge ap_clk) begin
        af_q <= (int'(count_sel) >= AF_THRESH);
        ae_q <= (int'(count_sel) <= AE_THRESH);
    end

    assign in0_V.tready = in_ready;
    assign out_V.tvalid = out_valid;
    assign count        = count_q;
    assign maxcount     = max_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: doc/streaming_fifo_param.md
# streaming_fifo_param

Parametrised AXI-Stream FIFO that succeeds the fixed-depth SRL-based StreamingFIFO instances placed between FINN dataflow layers. It generalises data width and depth, including non-power-of-two depths, and stores data in an inferred simple-dual-port RAM with a registered output stage. Beyond count/maxcount monitoring, it adds almost-full/almost-empty flags, a maxcount clear and a synchronous flush. It sits between producer and consumer layers in the stitched accelerator.

## Interface
- WIDTH, 72, stream data width in bits (≥1)
- DEPTH, 6272, capacity in words (≥2, any integer)
- AF_THRESH, DEPTH-16, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 16, almost_empty asserts when count ≤ AE_THRESH
- CNT_W, $clog2(DEPTH+1), derived local parameter; not user-set

- ap_clk  in  1  sole clock; all logic on rising edge
- ap_rst  in  1  reset: synchronous, active-high
- flush  in  1  synchronous discard of all stored words
- maxcount_clr  in  1  restart high-water-mark tracking
- count  out  CNT_W  words currently held
- maxcount  out  CNT_W  high-water mark of count
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- in0_V_TDATA  in  WIDTH  input data
- in0_V_TVALID  in  1  input valid
- in0_V_TREADY  out  1  input ready
- out_V_TDATA  out  WIDTH  output data
- out_V_TVALID  out  1  output valid
- out_V_TREADY  in  1  output ready

## Operation
- Storage: DEPTH-entry RAM (write pointer wr_ptr, read pointer rd_ptr) plus one output register (out_V_TDATA, out_V_TVALID). count = RAM occupancy + out_V_TVALID.
- Pointers wrap from DEPTH-1 to 0 by explicit compare. No power-of-two assumption.
- Push when in0_V_TVALID & in0_V_TREADY: write RAM[wr_ptr], advance wr_ptr.
- Pop when out_V_TVALID & out_V_TREADY.
- Output refill: when RAM is non-empty and (!out_V_TVALID or pop), load the output register from RAM[rd_ptr], advance rd_ptr, and set out_V_TVALID. This is a synchronous read.
- in0_V_TREADY = !ap_rst & !flush & (count != DEPTH). It is combinational from registered count. There is no dependence on out_V_TREADY, so full stays full even when a pop occurs in the same cycle.
- count_next = count + push - pop. Simultaneous push and pop leave count unchanged.
- maxcount update, in priority order:
  - ap_rst: maxcount ← 0.
  - flush & maxcount_clr: maxcount ← 0.
  - maxcount_clr: maxcount ← count_next.
  - Otherwise: maxcount ← max(maxcount, count_next).
- flush: in0_V_TREADY is forced 0 and out_V_TVALID is masked to 0 in that cycle. At the edge, pointers, count and output valid are cleared. maxcount is retained unless maxcount_clr is also high.
- almost_full and almost_empty are registered from count_next. They are exact on the same cycle as count.
- Reset values:
  - count = 0, maxcount = 0, out_V_TVALID = 0, out_V_TDATA = 0.
  - in0_V_TREADY = 0 while ap_rst is high.
  - almost_full = (0 ≥ AF_THRESH), almost_empty = 1.
- Reset mid-operation discards all contents. There is no partial transfer: a handshake coinciding with ap_rst is not counted.
- No overflow or underflow is possible. Writes only occur with READY high, and reads only occur with RAM non-empty.

## Timing
- Write-to-read latency: a word accepted at edge t is written to RAM at t, loaded into the output register at edge t+1, and visible with out_V_TVALID = 1 after edge t+1.
- Steady state: one word per cycle in and out with both sides active. No bubble while the RAM is non-empty.
- Pop at edge t with RAM non-empty gives a new word valid after edge t; with RAM empty, out_V_TVALID = 0 after t.
- out_V_TDATA and out_V_TVALID are driven directly from flops; they hold stable while valid & !ready (AXI-S compliant).
- count, maxcount and the flags all update at the same edge as the handshake causing them.

## Structure
- Package streaming_fifo_pkg holds:
  - the clog2 helper;
  - the count-width computation function;
  - a pointer-wrap increment function.
- Sub-module fifo_sdp_ram (WIDTH, DEPTH): one write port, one synchronous read port with read enable, no reset on the array. It is inferred as BRAM/URAM.
- The top level holds pointers, count and maxcount logic, flags, and the output register.

## Test plan
- Fill: DEPTH = 5, AF = 4, AE = 1, out_V_TREADY = 0, push 6 words 0x01..0x06.
  - in0_V_TREADY drops after the 5th; count = 5, maxcount = 5, almost_full = 1.
  - out_V_TDATA = 0x01 after the first push + 1 edge.
- Streaming: DEPTH = 6272, WIDTH = 72, continuous valid/ready on both sides, 10000 words of incrementing data.
  - The output sequence matches the input exactly; count stays ≤ 2.
  - Pointers wrap at 6271→0 with no error.
- Simultaneous push and pop at full: count = DEPTH.
  - in0_V_TREADY = 0 for that cycle, pop occurs, count = DEPTH-1 after the edge.
- Flush: hold 3 words, maxcount = 3, assert flush for one cycle with in0_V_TVALID = 1.
  - No word is accepted; count = 0, out_V_TVALID = 0, maxcount = 3.
  - Next push appears at output two edges later.
- maxcount_clr: after maxcount = 7 and count = 2, pulse maxcount_clr with a concurrent push → maxcount = 3.
  - maxcount_clr together with flush → maxcount = 0.
- Reset mid-stream: ap_rst high for one cycle with 4 words stored.
  - Outputs take their reset values next cycle.
  - Data pushed after reset emerges first, with no stale words.
